// File: rtl/soc_lite.sv
// Lite SoC top: 32-bit hex counter shown on an 8-digit multiplexed 7-segment display, plus LEDs.
// Optional macro BLANK_LEADING_ZERO_EN turns off leading-zero digits (digit 0 always shown).
module soc_lite #(
  parameter int SCAN_DIV = 100000,
  parameter int TICK_DIV = 10000000
) (
  input  logic        clk,
  input  logic        resetn,
  output logic [7:0]  num_csn,
  output logic [6:0]  num_a_g,
  output logic [15:0] led,
  input  logic [7:0]  switch
);

  localparam int DATA_W = 32;
  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [SCAN_W-1:0] scan_cnt_p0;
  logic [TICK_W-1:0] tick_cnt_p0;
  logic [2:0]        idx_p0;
  logic [DATA_W-1:0] num_data_p0;

  logic [7:0]  num_csn_p1;
  logic [6:0]  num_a_g_p1;
  logic [15:0] led_p1;

  logic              scan_wrap;
  logic              tick;
  logic [DATA_W-1:0] num_data_nxt;
  logic [DATA_W-1:0] digit_shift;
  logic              blank;
  logic [7:0]        csn_nxt;
  logic [6:0]        seg_nxt;

  function automatic logic [6:0] seg7(input logic [3:0] hex);
    logic [6:0] s;
    case (hex)
      4'h0: s = 7'h7E;  4'h1: s = 7'h30;  4'h2: s = 7'h6D;  4'h3: s = 7'h79;
      4'h4: s = 7'h33;  4'h5: s = 7'h5B;  4'h6: s = 7'h5F;  4'h7: s = 7'h70;
      4'h8: s = 7'h7F;  4'h9: s = 7'h7B;  4'hA: s = 7'h77;  4'hB: s = 7'h1F;
      4'hC: s = 7'h4E;  4'hD: s = 7'h3D;  4'hE: s = 7'h4F;  default: s = 7'h47;
    endcase
    return s;
  endfunction

  assign scan_wrap = (scan_cnt_p0 == SCAN_W'(SCAN_DIV - 1));
  assign tick      = (tick_cnt_p0 == TICK_W'(TICK_DIV - 1));

  // Clear beats count; pause only gates the tick, counters keep running.
  always_comb begin
    num_data_nxt = num_data_p0;
    if (switch[2]) begin
      num_data_nxt = '0;
    end else if (tick && !switch[0]) begin
      num_data_nxt = switch[1] ? num_data_p0 - DATA_W'(1) : num_data_p0 + DATA_W'(1);
    end
  end

  // Shifting by 4*idx puts the selected nibble at [3:0]; all-zero result means
  // every digit from idx upward is zero.
  always_comb begin
    digit_shift = num_data_p0 >> {idx_p0, 2'b00};
    csn_nxt     = ~(8'h01 << idx_p0);
    seg_nxt     = seg7(digit_shift[3:0]);
`ifdef BLANK_LEADING_ZERO_EN
    blank = (idx_p0 != 3'd0) && (digit_shift == '0);
`else
    blank = 1'b0;
`endif
    if (blank) begin
      csn_nxt = 8'hFF;
      seg_nxt = 7'h00;
    end
  end

  // Stage p0: scan/tick counters and the displayed value
  always_ff @(posedge clk) begin
    if (resetn) begin
      scan_cnt_p0 <= '0;
      tick_cnt_p0 <= '0;
      idx_p0      <= '0;
      num_data_p0 <= '0;
    end else begin
      if (scan_wrap) begin
        scan_cnt_p0 <= '0;
        idx_p0      <= idx_p0 + 3'd1;
      end else begin
        scan_cnt_p0 <= scan_cnt_p0 + SCAN_W'(1);
      end
      tick_cnt_p0 <= tick ? '0 : tick_cnt_p0 + TICK_W'(1);
      num_data_p0 <= num_data_nxt;
    end
  end

  // Stage p1: registered pin drivers, one cycle behind p0
  always_ff @(posedge clk) begin
    if (resetn) begin
      num_csn_p1 <= 8'hFE;
      num_a_g_p1 <= 7'h7E;
      led_p1     <= 16'hFFFF;
    end else begin
      num_csn_p1 <= csn_nxt;
      num_a_g_p1 <= seg_nxt;
      led_p1     <= ~num_data_p0[15:0];
    end
  end

  assign num_csn = num_csn_p1;
  assign num_a_g = num_a_g_p1;
  assign led     = led_p1;

endmodule

// File: tb/tb_soc_lite.sv
// Bench for soc_lite with SCAN_DIV=2, TICK_DIV=4; a cycle-count based reference model predicts every output.
// Define BLANK_LEADING_ZERO_EN for both files to check the blanking build.
module tb_soc_lite;

  localparam int SCAN_DIV = 2;
  localparam int TICK_DIV = 4;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic [7:0]  switch = 8'h00;
  logic [7:0]  num_csn;
  logic [6:0]  num_a_g;
  logic [15:0] led;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: displayed value plus cycles elapsed since reset.
  logic [31:0] md;
  int          ncyc;
  logic [7:0]  exp_csn;
  logic [6:0]  exp_seg;
  logic [15:0] exp_led;
  logic [6:0]  seg_tab [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

  soc_lite #(.SCAN_DIV(SCAN_DIV), .TICK_DIV(TICK_DIV)) dut (
    .clk(clk), .resetn(resetn), .num_csn(num_csn), .num_a_g(num_a_g),
    .led(led), .switch(switch)
  );

  always #5 clk = ~clk;

  // Predict the outputs the coming posedge will produce, then clock and settle.
  task automatic advance();
    int i;
    logic [31:0] upper;
    if (resetn) begin
      exp_csn = 8'hFE; exp_seg = 7'h7E; exp_led = 16'hFFFF;
      md = 32'd0; ncyc = 0;
    end else begin
      i = (ncyc / SCAN_DIV) % 8;
      upper = md >> (4 * i);
      exp_csn = ~(8'h01 << i);
      exp_seg = seg_tab[upper[3:0]];
`ifdef BLANK_LEADING_ZERO_EN
      if (i > 0 && upper == 32'd0) begin
        exp_csn = 8'hFF; exp_seg = 7'h00;
      end
`endif
      exp_led = ~md[15:0];
      if (switch[2]) md = 32'd0;
      else if ((ncyc % TICK_DIV) == TICK_DIV - 1 && !switch[0])
        md = switch[1] ? md - 32'd1 : md + 32'd1;
      ncyc++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b1; switch = 8'h00;
    for (int k = 0; k < 3; k++) begin
      advance();
      vectors++;
      if ({num_csn, num_a_g, led} !== {8'hFE, 7'h7E, 16'hFFFF}) begin
        miscompares++;
        $display("FAIL reset cyc%0d: csn=%h seg=%h led=%h, want csn=fe seg=7e led=ffff",
                 k, num_csn, num_a_g, led);
      end
    end
  endtask

  task automatic test_count_up();
    resetn = 1'b0; switch = 8'h00;
    for (int k = 0; k < 5; k++) advance();
    vectors++;
    if (led !== 16'hFFFE) begin
      miscompares++;
      $display("FAIL first_tick: led=%h, want fffe", led);
    end
    // Run to 0x2A and beyond, covering every hex digit in the low nibble
    for (int k = 0; k < 200; k++) begin
      advance();
      vectors++;
      if ({num_csn, num_a_g, led} !== {exp_csn, exp_seg, exp_led}) begin
        miscompares++;
        $display("FAIL count_up k=%0d: csn=%h seg=%h led=%h, want csn=%h seg=%h led=%h",
                 k, num_csn, num_a_g, led, exp_csn, exp_seg, exp_led);
      end
    end
  endtask

  task automatic test_count_down();
    resetn = 1'b1; switch = 8'h00;
    advance();
    resetn = 1'b0; switch = 8'h02;
    for (int k = 0; k < 5; k++) advance();
    vectors++;
    if (led !== 16'h0000) begin
      miscompares++;
      $display("FAIL wrap_down: led=%h, want 0000", led);
    end
    for (int k = 0; k < 60; k++) begin
      advance();
      vectors++;
      if ({num_csn, num_a_g, led} !== {exp_csn, exp_seg, exp_led}) begin
        miscompares++;
        $display("FAIL count_down k=%0d: csn=%h seg=%h led=%h, want csn=%h seg=%h led=%h",
                 k, num_csn, num_a_g, led, exp_csn, exp_seg, exp_led);
      end
    end
  endtask

  task automatic test_pause_clear();
    switch = 8'h01;
    for (int k = 0; k < 20; k++) begin
      advance();
      vectors++;
      if ({num_csn, num_a_g, led} !== {exp_csn, exp_seg, exp_led}) begin
        miscompares++;
        $display("FAIL pause k=%0d: csn=%h seg=%h led=%h, want csn=%h seg=%h led=%h",
                 k, num_csn, num_a_g, led, exp_csn, exp_seg, exp_led);
      end
    end
    switch = 8'h05;
    advance();
    advance();
    vectors++;
    if (led !== 16'hFFFF) begin
      miscompares++;
      $display("FAIL clear: led=%h, want ffff", led);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 3000; k++) begin
      if (k % 40 == 0) begin
        switch = 8'($urandom);
        if ($urandom_range(7, 0) != 0) switch[2] = 1'b0;
        if ($urandom_range(2, 0) != 0) switch[0] = 1'b0;
      end
      resetn = ($urandom_range(299, 0) == 0);
      advance();
      vectors++;
      if ({num_csn, num_a_g, led} !== {exp_csn, exp_seg, exp_led}) begin
        miscompares++;
        $display("FAIL random k=%0d sw=%h rst=%b: csn=%h seg=%h led=%h, want csn=%h seg=%h led=%h",
                 k, switch, resetn, num_csn, num_a_g, led, exp_csn, exp_seg, exp_led);
      end
    end
  endtask

  initial begin
    md = 32'd0; ncyc = 0;
    test_reset();
    test_count_up();
    test_count_down();
    test_pause_clear();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
